// File: rtl/pipeline_pkg.sv
// Shared fetch/decode pipeline constants: address width, instruction size,
// reset PC and the PCsrc select encoding used by the PC register mux.
package pipeline_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned INSTR_BYTES = 2;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  // PCsrc encoding driven by the control unit
  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;
  localparam logic [1:0] PC_RETURN = 2'b11;

endpackage

// File: rtl/return_address_stack_if.sv
// Control-unit <-> return address stack bundle.
// Optional RAS_CHECKPOINT_EN adds the checkpoint/restore strobes.
interface return_address_stack_if #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = pipeline_pkg::ADDR_W
) ();

  logic                     stall;
  logic                     push;
  logic [ADDR_W-1:0]        push_addr;
  logic                     pop;
  logic [ADDR_W-1:0]        return_address;
  logic                     valid;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     underflow;
`ifdef RAS_CHECKPOINT_EN
  logic                     checkpoint;
  logic                     restore;

  modport master (
    output stall, push, push_addr, pop, checkpoint, restore,
    input  return_address, valid, count, overflow, underflow
  );
  modport slave (
    input  stall, push, push_addr, pop, checkpoint, restore,
    output return_address, valid, count, overflow, underflow
  );
`else
  modport master (
    output stall, push, push_addr, pop,
    input  return_address, valid, count, overflow, underflow
  );
  modport slave (
    input  stall, push, push_addr, pop,
    output return_address, valid, count, overflow, underflow
  );
`endif

endinterface

// File: rtl/ras_regfile.sv
// DEPTH x ADDR_W storage for the return address stack: one synchronous write
// port, one asynchronous read port, asynchronous clear to zero.
module ras_regfile #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem [DEPTH];

  // Entry storage; reset wipes every entry immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_address_stack.sv
// Return address stack feeding the fetch unit's PC_RETURN input.
// Circular LIFO: a push on a full stack overwrites the oldest entry.
// Optional macro RAS_CHECKPOINT_EN adds a one-deep snapshot of tos, count and
// the top entry for mispredict recovery.
module return_address_stack #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = pipeline_pkg::ADDR_W
) (
  input logic                   clk,
  input logic                   reset_n,
  return_address_stack_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  tos_q, tos_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [ADDR_W-1:0] wdata;
  logic [ADDR_W-1:0] top;

  ras_regfile #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr   (tos_q),
    .rdata   (top)
  );

`ifdef RAS_CHECKPOINT_EN
  logic [PTR_W-1:0]  snap_tos_q;
  logic [CNT_W-1:0]  snap_count_q;
  logic [ADDR_W-1:0] snap_top_q;

  // Snapshot capture; a coincident restore consumes the old snapshot instead
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_tos_q   <= '0;
      snap_count_q <= '0;
      snap_top_q   <= '0;
    end else if (bus.checkpoint && !bus.restore) begin
      snap_tos_q   <= tos_q;
      snap_count_q <= count_q;
      snap_top_q   <= top;
    end
  end
`endif

  // Next-state for pointer, depth and sticky flags, plus the storage write
  always_comb begin
    tos_d       = tos_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = tos_q;
    wdata       = bus.push_addr;
`ifdef RAS_CHECKPOINT_EN
    if (bus.restore) begin
      // Restore wins over push/pop and ignores stall
      tos_d   = snap_tos_q;
      count_d = snap_count_q;
      we      = 1'b1;
      waddr   = snap_tos_q;
      wdata   = snap_top_q;
    end else
`endif
    if (!bus.stall) begin
      if (bus.push && bus.pop && count_q != '0) begin
        // Replace top entry in place
        we = 1'b1;
      end else if (bus.push) begin
        tos_d = tos_q + 1'b1;
        we    = 1'b1;
        waddr = tos_q + 1'b1;
        if (count_q == FULL) overflow_d = 1'b1;
        else                 count_d    = count_q + 1'b1;
      end else if (bus.pop) begin
        if (count_q == '0) begin
          underflow_d = 1'b1;
        end else begin
          tos_d   = tos_q - 1'b1;
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // Pointer, depth and flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tos_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tos_q       <= tos_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.return_address = (count_q != '0) ? top : '0;
  assign bus.valid          = (count_q != '0);
  assign bus.count          = count_q;
  assign bus.overflow       = overflow_q;
  assign bus.underflow      = underflow_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Testbench for return_address_stack. Reference model is a bounded queue:
// push_back (dropping the oldest when full), pop_back, replace back.
module tb_return_address_stack;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  return_address_stack_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  return_address_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [ADDR_W-1:0] mq[$];
  bit m_ovf;
  bit m_unf;

  function automatic logic [ADDR_W-1:0] m_top();
    return (mq.size() != 0) ? mq[mq.size()-1] : '0;
  endfunction

  task automatic idle_inputs();
    bus.stall = 1'b0;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.push_addr = '0;
`ifdef RAS_CHECKPOINT_EN
    bus.checkpoint = 1'b0;
    bus.restore = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    idle_inputs();
    #2 reset_n = 1'b0;
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle and advance the reference model by the same operation
  task automatic step(input bit ps, input bit pp, input bit st, input logic [ADDR_W-1:0] a);
    bus.push = ps;
    bus.pop = pp;
    bus.stall = st;
    bus.push_addr = a;
    @(posedge clk);
    #1;
    if (!st) begin
      if (ps && pp && mq.size() != 0) begin
        mq[mq.size()-1] = a;
      end else if (ps) begin
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          m_ovf = 1;
        end
        mq.push_back(a);
      end else if (pp) begin
        if (mq.size() == 0) m_unf = 1;
        else void'(mq.pop_back());
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    step(0, 0, 0, '0);
    checks++;
    if (bus.return_address !== 16'h0000) begin
      failures++; $display("FAIL reset_ret got=%h exp=0000", bus.return_address);
    end
    checks++;
    if (bus.valid !== 1'b0 || bus.count !== 4'd0) begin
      failures++; $display("FAIL reset_cnt got valid=%b count=%0d exp 0/0", bus.valid, bus.count);
    end
    checks++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got ovf=%b unf=%b exp 0/0", bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_push_pop();
    apply_reset();
    step(1, 0, 0, 16'h0010);
    step(1, 0, 0, 16'h0024);
    checks++;
    if (bus.return_address !== 16'h0024) begin
      failures++; $display("FAIL prepop_ret got=%h exp=0024", bus.return_address);
    end
    step(0, 1, 0, '0);
    checks++;
    if (bus.return_address !== 16'h0010 || bus.count !== 4'd1) begin
      failures++;
      $display("FAIL postpop got ret=%h count=%0d exp 0010/1", bus.return_address, bus.count);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 9; i++) step(1, 0, 0, 16'(2 + 2 * i));
    checks++;
    if (bus.count !== 4'd8 || bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow got count=%0d ovf=%b exp 8/1", bus.count, bus.overflow);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.return_address !== 16'(16'h0012 - 2 * k)) begin
        failures++;
        $display("FAIL ovf_pop%0d got=%h exp=%h", k, bus.return_address, 16'(16'h0012 - 2 * k));
      end
      step(0, 1, 0, '0);
    end
    checks++;
    if (bus.count !== 4'd0 || bus.valid !== 1'b0 || bus.return_address !== 16'h0000) begin
      failures++;
      $display("FAIL ovf_drain got count=%0d valid=%b ret=%h exp 0/0/0000",
               bus.count, bus.valid, bus.return_address);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    step(0, 1, 0, '0);
    checks++;
    if (bus.underflow !== 1'b1 || bus.count !== 4'd0 || bus.return_address !== 16'h0000) begin
      failures++;
      $display("FAIL underflow got unf=%b count=%0d ret=%h exp 1/0/0000",
               bus.underflow, bus.count, bus.return_address);
    end
    step(1, 0, 0, 16'h0050);
    checks++;
    if (bus.underflow !== 1'b1 || bus.count !== 4'd1) begin
      failures++;
      $display("FAIL unf_sticky got unf=%b count=%0d exp 1/1", bus.underflow, bus.count);
    end
    // push+pop on empty acts as plain push without underflow
    apply_reset();
    step(1, 1, 0, 16'h0066);
    checks++;
    if (bus.underflow !== 1'b0 || bus.count !== 4'd1 || bus.return_address !== 16'h0066) begin
      failures++;
      $display("FAIL pushpop_empty got unf=%b count=%0d ret=%h exp 0/1/0066",
               bus.underflow, bus.count, bus.return_address);
    end
  endtask

  task automatic test_replace_and_stall();
    apply_reset();
    step(1, 0, 0, 16'h0100);
    step(1, 0, 0, 16'h0200);
    step(1, 0, 0, 16'h0300);
    step(1, 1, 0, 16'h0040);
    checks++;
    if (bus.count !== 4'd3 || bus.return_address !== 16'h0040) begin
      failures++;
      $display("FAIL replace got count=%0d ret=%h exp 3/0040", bus.count, bus.return_address);
    end
    step(1, 0, 1, 16'h0777);
    step(0, 1, 1, '0);
    step(1, 1, 1, 16'h0888);
    checks++;
    if (bus.count !== 4'd3 || bus.return_address !== 16'h0040) begin
      failures++;
      $display("FAIL stall got count=%0d ret=%h exp 3/0040", bus.count, bus.return_address);
    end
    step(0, 1, 0, '0);
    checks++;
    if (bus.return_address !== 16'h0200) begin
      failures++; $display("FAIL replace_below got=%h exp=0200", bus.return_address);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1, 0, 0, 16'h1234);
    step(1, 0, 0, 16'h5678);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.count !== 4'd0 || bus.valid !== 1'b0 || bus.return_address !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset got count=%0d valid=%b ret=%h exp 0/0/0000",
               bus.count, bus.valid, bus.return_address);
    end
    apply_reset();
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 42,
           $urandom_range(0, 99) < 15, 16'($urandom));
      checks++;
      if (bus.return_address !== m_top() || bus.count !== 4'(mq.size()) ||
          bus.valid !== (mq.size() != 0) || bus.overflow !== m_ovf ||
          bus.underflow !== m_unf) begin
        failures++;
        $display("FAIL random[%0d] got ret=%h cnt=%0d v=%b o=%b u=%b exp ret=%h cnt=%0d o=%b u=%b",
                 n, bus.return_address, bus.count, bus.valid, bus.overflow, bus.underflow,
                 m_top(), mq.size(), m_ovf, m_unf);
      end
    end
  endtask

`ifdef RAS_CHECKPOINT_EN
  task automatic test_checkpoint();
    apply_reset();
    step(1, 0, 0, 16'h0020);
    step(1, 0, 0, 16'h0030);
    bus.checkpoint = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    step(1, 0, 0, 16'h0aaa);
    step(1, 0, 0, 16'h0bbb);
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    bus.restore = 1'b1;
    bus.stall = 1'b1;
    bus.push = 1'b1;
    bus.push_addr = 16'h0ccc;
    @(posedge clk);
    #1;
    idle_inputs();
    checks++;
    if (bus.count !== 4'd2 || bus.return_address !== 16'h0030) begin
      failures++;
      $display("FAIL restore got count=%0d ret=%h exp 2/0030", bus.count, bus.return_address);
    end
    apply_reset();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace_and_stall();
    test_async_reset();
    test_random();
`ifdef RAS_CHECKPOINT_EN
    test_checkpoint();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/return_address_stack.md
Name: return_address_stack

Overview:
- Producer side of the fetch unit's return-address input.
- On a call (JAL-type), pushes the link address (PC + 2). On a return, presents the most recent link address on return_address; the PC register loads it when PCsrc = 2'b11 and this block pops in the same edge.
- Circular LIFO storage, plus depth tracking and sticky error flags. Sits beside the PC register in the fetch stage; the control unit drives it.

Parameters:
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- ADDR_W, 16, address width in bits; matches the PC width.

Ports:
- clk  input  1  rising-edge clock, shared with the PC register.
- reset_n  input  1  asynchronous active-low reset.
- stall  input  1  pipeline stall; when 1, push and pop are ignored.
- push  input  1  call retiring from decode; write push_addr.
- push_addr  input  ADDR_W  link address (PC + 2) to save.
- pop  input  1  return taken this cycle (PCsrc = 2'b11).
- return_address  output  ADDR_W  top-of-stack entry; combinational from registers.
- valid  output  1  stack non-empty (count != 0).
- count  output  $clog2(DEPTH)+1  number of live entries, 0..DEPTH.
- overflow  output  1  sticky; a push occurred while count == DEPTH.
- underflow  output  1  sticky; a pop occurred while count == 0.

Behaviour:
- Reset (async, reset_n = 0):
  - tos pointer = 0, count = 0, overflow = 0, underflow = 0.
  - All entries cleared to 0, so return_address = 0 and valid = 0.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Storage and output:
  - DEPTH x ADDR_W register array with a tos pointer that wraps modulo DEPTH.
  - return_address = mem[tos] whenever count > 0, otherwise 0. Zero latency: the value the PC samples at an edge is the value before that edge's pop.
- Per rising edge, when stall = 0:
  - push only:
    - tos <= tos + 1 (wraps), mem[tos + 1] <= push_addr.
    - If count < DEPTH: count increments.
    - If count == DEPTH: count holds, the oldest entry is silently overwritten, and overflow is set.
  - pop only:
    - If count > 0: tos <= tos - 1 (wraps) and count decrements; entries are not cleared.
    - If count == 0: tos and count hold, and underflow is set.
  - push and pop together:
    - mem[tos] <= push_addr; tos and count are unchanged. This replaces the top entry.
    - If count == 0, this behaves as a push only, and underflow is not set.
  - neither: state holds.
- stall = 1: no state change, and return_address stays stable.
- Sticky flags clear only on reset.
- Arithmetic: pointer arithmetic is $clog2(DEPTH) bits with natural wrap. push_addr is stored unmodified; no alignment check is performed.

Optional Feature:
- RAS_CHECKPOINT_EN adds two inputs:
  - checkpoint (1 bit): when 1 at an edge, snapshot tos, count, and mem[tos].
  - restore (1 bit): when 1, reload that snapshot into tos, count, and mem[tos] for branch-mispredict flushes.
- restore has priority over push and pop in the same cycle.
- restore ignores stall.
- checkpoint together with restore in the same cycle restores the old snapshot, then takes no new snapshot.
- The snapshot resets to all zeros.
- Without the macro: the ports are absent and there is no snapshot logic.

Decomposition:
- Shared package pipeline_pkg:
  - ADDR_W = 16.
  - INSTR_BYTES = 2.
  - RESET_PC = 16'h0000.
  - The PCsrc encoding constants: PC_NEXT = 2'b00, PC_JUMP = 2'b01, PC_BRANCH = 2'b10, PC_RETURN = 2'b11.
- One natural sub-module, ras_regfile: DEPTH x ADDR_W storage with one write port and one async read port, with async clear.
- Pointer, count, and flag logic stay in the top module.

Test Plan:
- Reset then idle: return_address = 16'h0000, valid = 0, count = 0, both flags 0.
- Push 16'h0010, then 16'h0024, then pop:
  - Before the pop edge, return_address = 16'h0024.
  - After the pop, return_address = 16'h0010 and count = 1.
- With DEPTH = 8, push 16'h0002 through 16'h0012 (9 pushes):
  - After the 9th push, count = 8 and overflow = 1.
  - Eight pops return 16'h0012 down to 16'h0004. The 16'h0002 entry is lost.
- Pop on an empty stack: underflow = 1, count = 0, return_address = 0. The flag persists across later pushes.
- Simultaneous push 16'h0040 and pop with count = 3: count stays 3 and top = 16'h0040. Pushes or pops issued with stall = 1 change nothing.
- RAS_CHECKPOINT_EN:
  - Checkpoint at count = 2 with top = 16'h0030.
  - Then push twice and pop three times.
  - Then restore: count = 2 and return_address = 16'h0030. Asserting reset_n = 0 mid-sequence clears everything immediately.
